dsub32_serial: RTL

- Digit-serial 32-bit subtractor: diff = A − B − bin, computed one 4-bit digit per clock, LSB digit first, with a registered borrow between digits.
- Complements the team's combinational 4-bit-block carry-skip adders on the subtract side.
- Targets area-constrained datapaths where an 8-cycle latency is acceptable.
- Uses a start/busy/done handshake and also produces borrow, signed-overflow and zero flags.

---
 rtl/dsub32_serial.sv | 73 +++++++
 1 files changed

// File: rtl/dsub32_serial.sv
// dsub32_serial: digit-serial subtractor, diff = A - B - bin, one DIGIT-bit digit per clock, LSB first
// Ports: clk, rst (sync, active-high); start/A/B/bin request, captured in IDLE;
//        busy while running, done one-cycle pulse; diff, bout (unsigned borrow), ovf (signed overflow), zero
module dsub32_serial #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);
   localparam int N  = WIDTH / DIGIT;
   localparam int KW = N > 1 ? $clog2(N) : 1;
   typedef enum logic {IDLE, RUN} state_t;
   state_t           state, state_n;
   logic [WIDTH-1:0] a_q, b_q, diff_n;
   logic [KW-1:0]    k;
   logic             borrow, last;
   logic [DIGIT:0]   step;
   // step[DIGIT] is the borrow out of the current digit
   always_comb begin
      step    = {1'b0, a_q[k*DIGIT +: DIGIT]} - {1'b0, b_q[k*DIGIT +: DIGIT]} - {{DIGIT{1'b0}}, borrow};
      diff_n  = diff;
      diff_n[k*DIGIT +: DIGIT] = step[DIGIT-1:0];
      last    = k == KW'(N - 1);
      state_n = state == IDLE ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
      busy    = state == RUN;
   end
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else     state <= state_n;
   always_ff @(posedge clk) begin
      if (rst) begin
         done   <= 1'b0;
         diff   <= '0;
         bout   <= 1'b0;
         ovf    <= 1'b0;
         zero   <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         borrow <= 1'b0;
         k      <= '0;
      end else begin
         done <= 1'b0;
         if (state == IDLE && start) begin
            a_q    <= A;
            b_q    <= B;
            borrow <= bin;
            k      <= '0;
         end else if (state == RUN) begin
            diff   <= diff_n;
            borrow <= step[DIGIT];
            k      <= k + 1'b1;
            if (last) begin
               done <= 1'b1;
               bout <= step[DIGIT];
               // the last digit carries the result MSB
               ovf  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (step[DIGIT-1] != a_q[WIDTH-1]);
               zero <= diff_n == '0;
            end
         end
      end
   end
endmodule
